// File: rtl/sar_search_if.sv
// Handshake/bus bundle between the SAR search controller and its comparator/requester.
// master: the search controller. slave: the side that requests searches and answers trials.
interface sar_search_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic             ge_in;
  logic [WIDTH-1:0] trial;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    input  start,
    input  ge_in,
    output trial,
    output busy,
    output done,
    output result
  );

  modport slave (
    output start,
    output ge_in,
    input  trial,
    input  busy,
    input  done,
    input  result
  );
endinterface

// File: rtl/sar_search.sv
// Successive-approximation search controller driving a magnitude comparator.
// Builds, MSB first, the largest code for which the comparator reports target >= trial.
// Optional macro SAR_SETTLE_EN inserts a SETTLE state after every trial update so each
// trial is held for two cycles and the decision is taken on the second.
module sar_search #(
  parameter int unsigned WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  sar_search_if.master bus
);

`ifdef SAR_SETTLE_EN
  typedef enum logic [1:0] {StIdle, StTry, StSettle, StDone} state_t;
  localparam state_t StAfterUpdate = StSettle;
`else
  typedef enum logic [1:0] {StIdle, StTry, StDone} state_t;
  localparam state_t StAfterUpdate = StTry;
`endif

  localparam logic [WIDTH-1:0] MsbOnly = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state_q, state_d;
  // Bit under test kept one-hot, so stepping down is a shift rather than a decrement.
  logic [WIDTH-1:0] bit_q, bit_d;
  logic [WIDTH-1:0] trial_q, trial_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] kept;

  assign bus.trial  = trial_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StAfterUpdate;
        end
      end
`ifdef SAR_SETTLE_EN
      StSettle: state_d = StTry;
`endif
      StTry:  state_d = bit_q[0] ? StDone : StAfterUpdate;
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Next values of trial code, bit pointer and the registered outputs.
  always_comb begin
    trial_d  = trial_q;
    bit_d    = bit_q;
    result_d = result_q;
    busy_d   = busy_q;
    done_d   = done_q;
    // Trial with the current bit resolved: dropped when the target is below the trial.
    kept     = bus.ge_in ? trial_q : (trial_q & ~bit_q);
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          trial_d = MsbOnly;
          bit_d   = MsbOnly;
          busy_d  = 1'b1;
          done_d  = 1'b0;
        end
      end
      StTry: begin
        // On the last bit the shifted pointer is zero, so trial simply keeps the final code.
        trial_d = kept | (bit_q >> 1);
        bit_d   = bit_q >> 1;
        if (bit_q[0]) begin
          result_d = kept;
          busy_d   = 1'b0;
          done_d   = 1'b1;
        end
      end
      StDone: begin
        done_d = 1'b0;
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      trial_q  <= '0;
      bit_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      trial_q  <= trial_d;
      bit_q    <= bit_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_sar_search.sv
// Self-checking bench for sar_search: directed cases plus random targets against a
// behavioural model (largest code not above the target, found by exhaustive scan).
module tb_sar_search;
  localparam int unsigned W = 8;
`ifdef SAR_SETTLE_EN
  localparam int Step = 2;
`else
  localparam int Step = 1;
`endif
  localparam int Lat    = W * Step;
  localparam int Period = Lat + 2;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp  = 0;
  int   n_err  = 0;
  int   target = 0;
  bit   force0 = 1'b0;
  int   seen [W];
  int   last;
  int   pulses;
  int   seq100 [W];

  sar_search_if #(.WIDTH(W)) bus ();

  sar_search #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Comparator model: target >= trial, or never true when force0 is set.
  assign bus.ge_in = !force0 && (target >= int'(bus.trial));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
    end
  endtask

  // Largest code c in [0, 2^W) for which the comparator says target >= c.
  function automatic int ref_result(input int tgt, input bit f0);
    int best = 0;
    for (int c = 0; c < (1 << W); c++) begin
      if (!f0 && tgt >= c) best = c;
    end
    return best;
  endfunction

  // Probe k of a binary search converging on res: bits already decided plus the next bit.
  function automatic int ref_trial(input int res, input int k);
    int hi = W - k;
    return ((res >> hi) << hi) | (1 << (W - 1 - k));
  endfunction

  // One complete search; poke pulses start during TRY and during DONE (must be ignored).
  task automatic search(input int tgt, input bit f0, input bit poke);
    int want = ref_result(tgt, f0);
    target    = tgt;
    force0    = f0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 0; k < int'(W); k++) begin
      for (int s = 0; s < Step; s++) begin
        if (s == 0) seen[k] = int'(bus.trial);
        chk($sformatf("trial[%0d] tgt %0d", k, tgt), 32'(bus.trial), ref_trial(want, k));
        chk("busy_during", 32'(bus.busy), 1);
        chk("done_during", 32'(bus.done), 0);
        bus.start = poke && (k == 3) && (s == 0);
        @(negedge clk);
      end
    end
    chk("done_pulse", 32'(bus.done), 1);
    chk("busy_at_done", 32'(bus.busy), 0);
    chk($sformatf("result tgt %0d", tgt), 32'(bus.result), want);
    chk("trial_final", 32'(bus.trial), want);
    bus.start = poke;
    @(negedge clk);
    bus.start = 1'b0;
    chk("done_drop", 32'(bus.done), 0);
    chk("busy_after", 32'(bus.busy), 0);
    chk("result_hold", 32'(bus.result), want);
    @(negedge clk);
    chk("idle_busy", 32'(bus.busy), 0);
  endtask

  initial begin
    seq100    = '{8'h80, 8'h40, 8'h60, 8'h70, 8'h68, 8'h64, 8'h66, 8'h65};
    rst       = 1'b1;
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_trial", 32'(bus.trial), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_result", 32'(bus.result), 0);
    rst = 1'b0;
    @(negedge clk);

    // Directed: target 100 with the documented trial sequence.
    search(100, 1'b0, 1'b0);
    for (int k = 0; k < int'(W); k++) chk($sformatf("seq100[%0d]", k), seen[k], seq100[k]);

    // Boundaries.
    search(0, 1'b0, 1'b0);
    search(255, 1'b0, 1'b0);
    search(1000, 1'b0, 1'b0);
    search(0, 1'b1, 1'b0);

    // start pokes during TRY and DONE are ignored.
    search(37, 1'b0, 1'b1);

    // Reset in the 4th TRY cycle aborts the search and clears the last result.
    target    = 100;
    force0    = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_trial", 32'(bus.trial), 0);
    chk("midrst_busy", 32'(bus.busy), 0);
    chk("midrst_done", 32'(bus.done), 0);
    chk("midrst_result", 32'(bus.result), 0);
    @(negedge clk);
    chk("midrst_stay_idle", 32'(bus.busy), 0);
    search(77, 1'b0, 1'b0);

    // start held high: restarts only from IDLE, one done per Period cycles.
    target    = 200;
    bus.start = 1'b1;
    last      = -1;
    pulses    = 0;
    for (int c = 0; c < 3 * Period + 4; c++) begin
      @(negedge clk);
      chk("held_excl", 32'(bus.busy && bus.done), 0);
      if (bus.done) begin
        if (last >= 0) chk("held_period", c - last, Period);
        chk("held_result", 32'(bus.result), 200);
        last = c;
        pulses++;
      end else if (!bus.busy) begin
        chk("held_idle_gap", c - last, 1);
      end
    end
    chk("held_pulses", pulses, 3);
    bus.start = 1'b0;
    repeat (Period + 2) @(negedge clk);
    chk("held_settled", 32'(bus.busy), 0);

    // Random targets.
    for (int i = 0; i < 20; i++) search(int'($urandom_range(0, 300)), 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sar_search.md
# sar_search

Successive-approximation search controller: the driving side of the team's `ge` comparator. It presents trial codes on `trial` and consumes the comparator's decision `ge_in`, which is 1 when the external target is at least `trial`. From these decisions it builds, MSB first, the largest code for which `ge_in` = 1. It is used wherever a threshold, level or count has to be recovered bit-by-bit through a magnitude comparator, for example a DAC/comparator ADC loop or a threshold calibration.

## Interface
Parameters:
- `WIDTH`, default 8: width of the trial and result codes; legal values are 2..16.

Ports:
- `clk`  input  1: system clock; all state changes on the rising edge.
- `rst`  input  1: synchronous, active-high reset.
- `start`  input  1: request a new search; sampled only in IDLE.
- `ge_in`  input  1: comparator decision for the current `trial` (target >= trial); combinational from `trial`.
- `trial`  output  WIDTH: current trial code, registered; drives the comparator `b` side.
- `busy`  output  1: high while a search is in progress.
- `done`  output  1: one-cycle pulse when `result` is updated.
- `result`  output  WIDTH: last completed search value; holds until the next completion.

## Operation
- States: IDLE, TRY, (SETTLE when `SAR_SETTLE_EN` is defined), DONE.
- Reset, from any state including mid-search: state is IDLE; `trial`=0, `result`=0, `busy`=0, `done`=0; the bit index is cleared.
- IDLE with `start`=1:
  - `trial` <= 1<<(WIDTH-1)
  - bit index <= WIDTH-1
  - `busy` <= 1
  - next state TRY.
- IDLE with `start`=0: all outputs hold.
- TRY, at bit index i:
  - sample `ge_in`; if it is 0, clear bit i of `trial`.
  - if i>0: set bit i-1, decrement i, stay in TRY (or go to SETTLE).
  - if i==0: `result` <= the final trial value, `trial` holds that value, `busy` <= 0, `done` <= 1, next state DONE.
- DONE: `done` <= 0, next state IDLE. Lasts exactly one cycle.
- `start` is ignored in TRY, SETTLE and DONE. There is no queuing; a new request must be presented in IDLE.
- Arithmetic: bit manipulation only, with no adder.
- Boundary results:
  - target above all codes (`ge_in` always 1) gives result 2^WIDTH-1.
  - `ge_in` always 0 gives result 0.
- `ge_in` is assumed monotonic in `trial`. A non-monotonic input still terminates in exactly WIDTH decisions, but the result is undefined.

## Timing
- `start` is accepted at edge T0. `trial`=MSB-only and `busy`=1 are visible after T0.
- Without `SAR_SETTLE_EN`, decisions are taken at edges T0+1 through T0+WIDTH. `result`/`done` are valid after T0+WIDTH, and `done` drops after T0+WIDTH+1.
- Latency from `start` accepted to `done` high is WIDTH cycles. Back-to-back start-to-start spacing is at minimum WIDTH+2 cycles.
- `trial` changes only on decision edges. `ge_in` must settle within one clock period of a `trial` change.
- `busy` and `done` are never high in the same cycle.

## Configuration
- `SAR_SETTLE_EN` defined:
  - a SETTLE state is inserted after every trial update. `trial` holds for 2 cycles and `ge_in` is sampled only on the second one.
  - this supports a registered comparator or external settling.
  - latency becomes 2*WIDTH cycles, with decisions at T0+2, T0+4, and so on.
- `SAR_SETTLE_EN` undefined: the SETTLE state and its logic are absent, and latency is WIDTH cycles.
- Results are identical in both builds for the same monotonic target.

## Test plan
- WIDTH=8, `ge_in` modelled as (100 >= `trial`), pulse `start` -> trial sequence 0x80, 0x40, 0x60, 0x70, 0x68, 0x64, 0x66, 0x65; `result`=100 (0x64); `done` high for exactly 1 cycle, 8 cycles after start.
- Target 0 (`ge_in`=1 only when `trial`==0) -> `result`=0. Target 255 (`ge_in` always 1) -> `result`=255. Both complete with 8-cycle latency.
- `start` held high continuously -> searches restart only from IDLE; `done` pulses every 10 cycles; `busy` is low only during DONE and IDLE.
- Assert `rst` for 1 cycle at the 4th TRY cycle -> next cycle `trial`=0, `busy`=0, `done`=0, `result`=0; a following `start` runs a full, correct search.
- `start` pulsed during TRY and again during DONE -> ignored; exactly one `done` pulse, and `result` comes from the original search.
- With `SAR_SETTLE_EN` defined, target 100 -> `result`=100; `done` 16 cycles after start; each trial value held for 2 cycles.
